// File: rtl/stream_serializer.sv
// Width down-converter: one wide word per upstream handshake becomes RATIO
// narrow beats downstream, with a one-word skid slot for bubble-free streaming.
module stream_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH*RATIO-1:0] up_bus,
  input  logic                        up_val,
  output logic                        up_rdy,
  output logic [DATA_WIDTH-1:0]       dn_bus,
  output logic                        dn_val,
  output logic                        dn_last,
  input  logic                        dn_rdy
);

  localparam int WW = DATA_WIDTH * RATIO;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

  logic [WW-1:0] word_q, word_d;
  logic [WW-1:0] skid_q, skid_d;
  logic          word_val_q, word_val_d;
  logic          skid_val_q, skid_val_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          last_q, last_d;
  logic          up_rdy_q, up_rdy_d;

  logic          xfer;
  logic          free;
  logic          accept;
  logic [CW-1:0] beat_inc;

  assign xfer     = word_val_q & dn_rdy;
  assign free     = ~word_val_q | (xfer & last_q);
  assign accept   = up_val & up_rdy_q;
  assign beat_inc = beat_q + CW'(1);

  always_comb begin
    word_d     = word_q;
    word_val_d = word_val_q;
    beat_d     = beat_q;
    last_d     = last_q;
    skid_d     = skid_q;
    skid_val_d = skid_val_q;

    // Shift the emitted slice out so the next beat always sits at the output end.
    if (xfer) begin
      if (MSB_FIRST != 0) word_d = word_q << DATA_WIDTH;
      else                word_d = word_q >> DATA_WIDTH;
      beat_d = beat_inc;
      last_d = (beat_inc == LAST_BEAT);
    end

    if (free) begin
      beat_d = '0;
      last_d = 1'b0;
      // The skid word is older than anything upstream, so it goes first;
      // up_rdy is low while it is occupied, so no accept can collide.
      if (skid_val_q) begin
        word_d     = skid_q;
        word_val_d = 1'b1;
        skid_val_d = 1'b0;
      end else if (accept) begin
        word_d     = up_bus;
        word_val_d = 1'b1;
      end else begin
        word_val_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = up_bus;
      skid_val_d = 1'b1;
    end

    up_rdy_d = ~skid_val_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_val_q <= 1'b0;
      skid_val_q <= 1'b0;
      beat_q     <= '0;
      last_q     <= 1'b0;
      up_rdy_q   <= 1'b0;
    end else begin
      word_val_q <= word_val_d;
      skid_val_q <= skid_val_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      up_rdy_q   <= up_rdy_d;
    end
  end

  // Data storage carries no reset; its contents only matter when the matching valid is set.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    skid_q <= skid_d;
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign dn_bus = word_q[WW-1 -: DATA_WIDTH];
    end else begin : g_lsb
      assign dn_bus = word_q[DATA_WIDTH-1:0];
    end
  endgenerate

  assign dn_val  = word_val_q;
  assign dn_last = last_q;
  assign up_rdy  = up_rdy_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: LSB-first and MSB-first instances share stimulus
// and are compared against a word/beat queue model of the stream.
module tb_stream_serializer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int WW = DW * R;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] up_bus;
  logic          up_val;
  logic          dn_rdy;

  logic          up_rdy_l, dn_val_l, dn_last_l;
  logic [DW-1:0] dn_bus_l;
  logic          up_rdy_m, dn_val_m, dn_last_m;
  logic [DW-1:0] dn_bus_m;

  always #5 clk = ~clk;

  stream_serializer #(.DATA_WIDTH(DW), .RATIO(R), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .up_bus(up_bus), .up_val(up_val), .up_rdy(up_rdy_l),
    .dn_bus(dn_bus_l), .dn_val(dn_val_l), .dn_last(dn_last_l), .dn_rdy(dn_rdy)
  );

  stream_serializer #(.DATA_WIDTH(DW), .RATIO(R), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .up_bus(up_bus), .up_val(up_val), .up_rdy(up_rdy_m),
    .dn_bus(dn_bus_m), .dn_val(dn_val_m), .dn_last(dn_last_m), .dn_rdy(dn_rdy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pending source words, expected beats {last,data} per
  // ordering, and the count of words held inside the serializer.
  logic [WW-1:0] src_q[$];
  logic [DW:0]   lsb_q[$];
  logic [DW:0]   msb_q[$];
  int            words_in = 0;
  logic          exp_rdy  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    src_q.delete();
    lsb_q.delete();
    msb_q.delete();
    words_in = 0;
    exp_rdy  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("up_rdy_lsb", {31'd0, up_rdy_l}, {31'd0, exp_rdy});
    chk("up_rdy_msb", {31'd0, up_rdy_m}, {31'd0, exp_rdy});
    chk("dn_val_lsb", {31'd0, dn_val_l}, {31'd0, words_in > 0});
    chk("dn_val_msb", {31'd0, dn_val_m}, {31'd0, words_in > 0});
    if (words_in > 0) begin
      chk("dn_bus_lsb",  {24'd0, dn_bus_l},  {24'd0, lsb_q[0][DW-1:0]});
      chk("dn_last_lsb", {31'd0, dn_last_l}, {31'd0, lsb_q[0][DW]});
      chk("dn_bus_msb",  {24'd0, dn_bus_m},  {24'd0, msb_q[0][DW-1:0]});
      chk("dn_last_msb", {31'd0, dn_last_m}, {31'd0, msb_q[0][DW]});
    end
  endtask

  // Effect of the coming rising edge on the model.
  task automatic model_edge();
    logic          acc, xfer, last_beat;
    logic [WW-1:0] w;
    if (!rst) return;
    acc  = up_val && exp_rdy;
    xfer = (words_in > 0) && dn_rdy;
    if (xfer) begin
      last_beat = lsb_q[0][DW];
      void'(lsb_q.pop_front());
      void'(msb_q.pop_front());
      if (last_beat) words_in--;
    end
    if (acc) begin
      w = src_q.pop_front();
      for (int k = 0; k < R; k++) begin
        lsb_q.push_back({k == R-1, w[k*DW +: DW]});
        msb_q.push_back({k == R-1, w[(R-1-k)*DW +: DW]});
      end
      words_in++;
    end
    exp_rdy = (words_in < 2);
  endtask

  task automatic step(input logic rst_v, input logic gate, input logic dr);
    @(negedge clk);
    check_outputs();
    rst    = rst_v;
    up_val = gate && (src_q.size() > 0);
    up_bus = (src_q.size() > 0) ? src_q[0] : WW'($urandom);
    dn_rdy = dr;
    model_edge();
  endtask

  initial begin
    logic [3:0] pat;
    int         guard;
    rst    = 1'b0;
    up_val = 1'b0;
    up_bus = '0;
    dn_rdy = 1'b1;
    model_reset();

    // Reset release
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // Single word
    src_q.push_back(32'hDDCCBBAA);
    repeat (7) step(1'b1, 1'b1, 1'b1);

    // Back-to-back words
    src_q.push_back(32'h11223344);
    src_q.push_back(32'h55667788);
    repeat (11) step(1'b1, 1'b1, 1'b1);

    // Downstream stall pattern mid-word
    src_q.push_back(32'hA1B2C3D4);
    src_q.push_back(32'h0F1E2D3C);
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, pat[i % 4]);
    repeat (4) step(1'b1, 1'b1, 1'b1);

    // Skid full: active word stalled, two more offered
    src_q.push_back(32'hCAFEF00D);
    src_q.push_back(32'h12345678);
    src_q.push_back(32'h9ABCDEF0);
    repeat (5) step(1'b1, 1'b1, 1'b0);
    repeat (16) step(1'b1, 1'b1, 1'b1);

    // Reset mid-word
    src_q.push_back(32'hDDCCBBAA);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_dn_val_lsb", {31'd0, dn_val_l}, 32'd0);
    chk("rst_async_dn_val_msb", {31'd0, dn_val_m}, 32'd0);
    chk("rst_async_up_rdy", {31'd0, up_rdy_l}, 32'd0);
    model_reset();
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    src_q.push_back(32'h04030201);
    repeat (7) step(1'b1, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && src_q.size() < 4) src_q.push_back(WW'($urandom));
      step(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    // Drain
    guard = 0;
    while ((src_q.size() > 0 || words_in > 0) && guard < 200) begin
      step(1'b1, 1'b1, 1'b1);
      guard++;
    end
    chk("drain_timeout", guard, (guard < 200) ? guard : 32'd199);
    step(1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_serializer.md
# stream_serializer

Width down-converter for the valid/ready streaming fabric: accepts one wide word per upstream handshake and emits it downstream as `RATIO` narrow beats, flagging the final beat with `dn_last`. It is the narrow-side end of a wide datapath, feeding byte- or lane-wide consumers. It uses the same handshake discipline as the fabric's pipeline stages: every output is a flop, `up_rdy` is registered, and a one-word skid slot sustains back-to-back words with no bubble.

## Interface
- `DATA_WIDTH`, 8: narrow beat width in bits.
- `RATIO`, 4: beats per wide word; must be ≥ 2.
- `MSB_FIRST`, 0: 0 emits the least-significant slice first; 1 emits the most-significant slice first.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; asserts immediately, deasserts synchronously to `clk` at system level.
- `up_bus`  in  DATA_WIDTH*RATIO  wide word.
- `up_val`  in  1  wide word valid.
- `up_rdy`  out  1  registered ready to upstream.
- `dn_bus`  out  DATA_WIDTH  current narrow beat.
- `dn_val`  out  1  beat valid.
- `dn_last`  out  1  high on the final beat of a word; qualified by `dn_val`.
- `dn_rdy`  in  1  downstream ready.

## Operation
- Storage:
  - Active word: shift register `word_reg`, flag `word_val`, beat counter `beat_cnt` (0..RATIO-1, width `$clog2(RATIO)`).
  - Skid slot: `skid_reg`, `skid_val`.
- Outputs are flops only:
  - `dn_val` = `word_val`.
  - `dn_bus` = the low slice of `word_reg` (LSB-first), or the high slice (MSB_FIRST).
  - `dn_last` = `word_val & (beat_cnt == RATIO-1)`, kept as a flop set alongside the counter.
  - `up_rdy` = registered `~skid_val_next`.
- Beat transfer is `dn_val & dn_rdy`. On each transfer:
  - shift `word_reg` by `DATA_WIDTH` toward the emitted end;
  - increment `beat_cnt`.
- Word free this cycle: `free = ~word_val | (dn_val & dn_rdy & dn_last)`.
- Upstream accept is `up_val & up_rdy`:
  - if `free`, load `up_bus` into `word_reg`, set `word_val`, clear `beat_cnt`;
  - else write `skid_reg` and set `skid_val`.
- When `free` with `skid_val` set: load `word_reg` from `skid_reg` and clear `skid_val`. No upstream accept can collide with this, because `up_rdy` is low whenever `skid_val` is set.
- When `free` with no source: clear `word_val`, `dn_last`, `beat_cnt`.
- Stall (`dn_val & ~dn_rdy`): `dn_bus`, `dn_last` and `beat_cnt` hold; `dn_val` holds high.
- Data is never dropped or duplicated. Order is preserved across active word and skid.

## Timing
- Reset values: `up_rdy`=0, `dn_val`=0, `dn_last`=0, `beat_cnt`=0, `skid_val`=0. `word_reg`, `skid_reg` and `dn_bus` are not reset (don't-care).
- `up_rdy` rises on the first `clk` edge after `rst` deasserts.
- Latency: word accepted at edge t with the serializer idle gives `dn_val`=1 with beat 0 after edge t, i.e. in cycle t+1.
- Throughput: with `dn_rdy` held high, words stream at exactly one beat per cycle. Beat 0 of word n+1 directly follows `dn_last` of word n, with no gap.
- Upstream rate with `dn_rdy` high is at most one word per `RATIO` cycles. `up_rdy` falls for at most `RATIO-1` cycles per word.
- `up_rdy` falls only in the cycle after an accept (`up_val` was high), matching fabric rules.
- `dn_val` falls only after a transfer of a `dn_last` beat with no pending word.
- Reset mid-word: all valid state clears asynchronously; partial words are discarded. Output resumes with the next accepted word, starting at beat 0.

## Test plan
1. **Reset release.** Hold `rst`=0 for 3 cycles, then release -> `up_rdy`=0, `dn_val`=0 during reset; `up_rdy`=1 one cycle after release.
2. **Single word, LSB-first.** `DATA_WIDTH`=8, `RATIO`=4, `dn_rdy`=1; send `up_bus`=0xDDCCBBAA -> `dn_bus`=0xAA,0xBB,0xCC,0xDD on consecutive cycles; `dn_last` only with 0xDD; `dn_val` drops after.
3. **Back-to-back words, MSB-first.** `MSB_FIRST`=1; `up_val` held high with 0x11223344 then 0x55667788 -> 8 contiguous beats 0x11,0x22,0x33,0x44,0x55,…,0x88; `dn_last` on 0x44 and 0x88; `up_rdy` low while the skid is occupied.
4. **Downstream stall.** Toggle `dn_rdy` 1,0,0,1,… mid-word -> `dn_bus` stable across stall cycles; no beat lost or repeated; `beat_cnt` holds.
5. **Skid full.** `dn_rdy`=0 with one word active; offer two further words -> the second is accepted into the skid, then `up_rdy`=0 and the third is held until the active word's last beat transfers.
6. **Reset mid-word.** Assert `rst` after beat 1 of 0xDDCCBBAA -> `dn_val`=0 immediately. After release, 0x04030201 emits 0x01 first with `dn_last` on 0x04.
